store_and_release: RTL and testbench
====================================

STORE_AND_RELEASE -- requirements
Module: store_and_release

Interface
REQ-001 SHALL have parameter DATA_W, default 64: tuple payload width.
REQ-002 SHALL have parameter DEPTH, default 16: buffer entries, power of two and at least 2.
REQ-003 SHALL have parameter SEQ_W, default 32: tuple sequence-tag width, equal to the width of next.
REQ-004 clk  in  1  single clock, all logic on rising edge; reset is synchronous and active-high.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 s_data / s_seq / s_valid / s_last  in  DATA_W / SEQ_W / 1 / 1  upstream tuple, tag, valid, last-beat marker.
REQ-007 s_ready  out  1  upstream accept.
REQ-008 next  in  SEQ_W  global release index from command-and-control.
REQ-009 is_stored  out  1  head entry tag equals next.
REQ-010 release_data  in  1  pop the head into the output register.
REQ-011 local_last_processed  out  1  lane finished: last seen and buffer empty.
REQ-012 out_ready  out  1  output register can take a release this cycle.
REQ-013 m_data / m_valid  out  DATA_W / 1  downstream tuple and valid.
REQ-014 m_ready  in  1  downstream accept.
REQ-015 err  out  1  sticky protocol-error flag.
REQ-016 released_cnt / stall_cnt  out  32 / 32  statistics counters (see Configuration).

Function
REQ-017 Buffer SHALL be an in-order FIFO of DEPTH {seq,data} entries; push when s_valid and s_ready; s_ready = !full and state != DONE, with no push while full even if a pop happens the same cycle.
REQ-018 is_stored SHALL be combinational: !empty and head.seq == next, using equality only so that SEQ_W wrap-around is transparent.
REQ-019 out_ready SHALL equal !m_valid or m_ready.
REQ-020 On release_data and is_stored: pop the head; m_data = head.data and m_valid = 1 on the next cycle (latency 1).
REQ-021 m_valid SHALL clear after an m_ready handshake with no same-cycle release; a release coinciding with a handshake reloads the register with no bubble.
REQ-022 release_data asserted while !is_stored, or while !out_ready, SHALL be ignored (no pop, no change to m_data) and SHALL set err.
REQ-023 A head entry with seq older than next (next - head.seq in [1, 2^(SEQ_W-1))) SHALL be popped and discarded in one cycle and SHALL set err; a newer head waits.
REQ-024 State machine states: IDLE (no beat yet), ACTIVE, DRAINING (last pushed, buffer non-empty), DONE.
REQ-025 IDLE->ACTIVE on the first push; ACTIVE->DRAINING on a push with s_last; DRAINING->DONE when the buffer becomes empty; a last push into an empty buffer that is popped the same cycle goes ACTIVE->DONE directly.
REQ-026 local_last_processed = (state == DONE); DONE is absorbing until reset, and s_ready = 0 in DONE.
REQ-027 m_valid may remain high in DONE until drained; local_last_processed does not wait for it.
REQ-028 A push and a pop in the same cycle SHALL leave occupancy unchanged.

Reset
REQ-029 While reset is high: FIFO empty, state IDLE, m_valid 0, m_data 0, err 0, counters 0, is_stored 0, local_last_processed 0; s_ready 1 from the first cycle after release.
REQ-030 Reset asserted mid-operation SHALL discard all buffered entries and the output tuple within one cycle; m_ready is ignored during reset.

Configuration
REQ-031 Macro SAR_STATS_EN defined: released_cnt increments on each accepted release, stall_cnt increments on each cycle with !empty and !is_stored; both wrap at 2^32.
REQ-032 Without SAR_STATS_EN: ports released_cnt and stall_cnt remain present, are tied to 0, and no counter logic is built.

Verification
REQ-033 Push seq 0,1,2; next=0; pulse release_data three times with next stepping 0->1->2 -> m_data follows push order, each one cycle after its release, err=0.
REQ-034 Push seq 5; next=3 -> is_stored=0 and release_data sets err with no pop; next=5 -> is_stored=1.
REQ-035 Push seq 2 with next=4 -> entry discarded in one cycle, err=1, buffer empty.
REQ-036 Fill 16 entries -> s_ready=0; release with m_ready=1 -> s_ready=1 next cycle; occupancy returns to 15.
REQ-037 Push seq 7 with s_last; release -> state DONE, local_last_processed=1, s_ready=0; reset -> IDLE, all outputs 0.
REQ-038 With SAR_STATS_EN: 3 releases plus 4 stall cycles -> released_cnt=3, stall_cnt=4; without it both read 0.

Source files
------------

// File: rtl/store_and_release.sv
`default_nettype none
// ============================================================================
// store_and_release : in-order tuple buffer released against a global index;
// statistics counters built only with SAR_STATS_EN.  Revision 1.0
// ============================================================================
module store_and_release #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 16,
  parameter int SEQ_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] s_data,
  input  logic [SEQ_W-1:0]  s_seq,
  input  logic              s_valid,
  input  logic              s_last,
  output logic              s_ready,
  input  logic [SEQ_W-1:0]  next,
  output logic              is_stored,
  input  logic              release_data,
  output logic              local_last_processed,
  output logic              out_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              err,
  output logic [31:0]       released_cnt,
  output logic [31:0]       stall_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   c_FULL   = (AW+1)'(DEPTH);
  localparam logic [AW:0]   c_ONE    = (AW+1)'(1);
  localparam logic [AW-1:0] c_PTR1   = AW'(1);

  localparam logic [1:0] c_ST_IDLE   = 2'd0;
  localparam logic [1:0] c_ST_ACTIVE = 2'd1;
  localparam logic [1:0] c_ST_DRAIN  = 2'd2;
  localparam logic [1:0] c_ST_DONE   = 2'd3;

  logic [SEQ_W-1:0]  r_seq_mem  [DEPTH];
  logic [DATA_W-1:0] r_data_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr, r_rd_ptr;
  logic [AW:0]       r_count, w_count_next;
  logic [1:0]        r_state, w_state_next;
  logic [DATA_W-1:0] r_m_data;
  logic              r_m_valid, r_err;

  logic              w_empty, w_full, w_accepting;
  logic              w_push, w_pop, w_release_ok, w_release_bad, w_stale;
  logic [SEQ_W-1:0]  w_head_seq, w_age;
  logic [DATA_W-1:0] w_head_data;

  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == c_FULL);
  assign w_head_seq  = r_seq_mem[r_rd_ptr];
  assign w_head_data = r_data_mem[r_rd_ptr];

  assign s_ready   = !w_full && w_accepting;
  assign w_push    = s_valid && s_ready;
  assign is_stored = !w_empty && (w_head_seq == next);
  assign out_ready = !r_m_valid || m_ready;

  // Modular age of the head: non-zero with clear MSB means the index has passed it.
  assign w_age   = next - w_head_seq;
  assign w_stale = !w_empty && (w_age != '0) && !w_age[SEQ_W-1];

  assign w_release_ok  = release_data && is_stored && out_ready;
  assign w_release_bad = release_data && !(is_stored && out_ready);
  assign w_pop         = w_release_ok || w_stale;

  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + c_ONE;
      2'b01:   w_count_next = r_count - c_ONE;
      default: w_count_next = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_seq_mem[r_wr_ptr]  <= s_seq;
      r_data_mem[r_wr_ptr] <= s_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
      r_err     <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR1;
      r_count <= w_count_next;
      if (w_release_ok) begin
        r_m_valid <= 1'b1;
        r_m_data  <= w_head_data;
      end else if (m_ready) begin
        r_m_valid <= 1'b0;
      end
      if (w_release_bad || w_stale) r_err <= 1'b1;
    end
  end

  assign m_valid = r_m_valid;
  assign m_data  = r_m_data;
  assign err     = r_err;

  always_ff @(posedge clk) begin
    if (reset) r_state <= c_ST_IDLE;
    else       r_state <= w_state_next;
  end

  // Completion is judged on post-update occupancy so a same-cycle pop counts.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_ST_IDLE:   if (w_push) w_state_next = s_last ? c_ST_DRAIN : c_ST_ACTIVE;
      c_ST_ACTIVE: if (w_push && s_last)
                     w_state_next = (w_count_next == '0) ? c_ST_DONE : c_ST_DRAIN;
      c_ST_DRAIN:  if (w_count_next == '0) w_state_next = c_ST_DONE;
      default:     w_state_next = r_state;
    endcase
  end

  always_comb begin
    local_last_processed = (r_state == c_ST_DONE);
    w_accepting          = (r_state != c_ST_DONE);
  end

`ifdef SAR_STATS_EN
  logic [31:0] r_released_cnt, r_stall_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_released_cnt <= '0;
      r_stall_cnt    <= '0;
    end else begin
      if (w_release_ok)            r_released_cnt <= r_released_cnt + 32'd1;
      if (!w_empty && !is_stored)  r_stall_cnt    <= r_stall_cnt + 32'd1;
    end
  end

  assign released_cnt = r_released_cnt;
  assign stall_cnt    = r_stall_cnt;
`else
  assign released_cnt = '0;
  assign stall_cnt    = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_store_and_release.sv
`default_nettype none
// Self-checking bench for store_and_release: vector table, corner sequences, random vs queue model.
module tb_store_and_release;

  localparam int DATA_W = 64;
  localparam int DEPTH  = 16;
  localparam int SEQ_W  = 32;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [DATA_W-1:0] s_data = '0;
  logic [SEQ_W-1:0]  s_seq = '0;
  logic              s_valid = 1'b0, s_last = 1'b0;
  logic              s_ready;
  logic [SEQ_W-1:0]  nxt = '0;
  logic              is_stored;
  logic              release_data = 1'b0;
  logic              local_last_processed, out_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready = 1'b0;
  logic              err;
  logic [31:0]       released_cnt, stall_cnt;

  int checks = 0;
  int errors = 0;

  store_and_release #(.DATA_W(DATA_W), .DEPTH(DEPTH), .SEQ_W(SEQ_W)) dut (
    .clk(clk), .reset(reset),
    .s_data(s_data), .s_seq(s_seq), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .next(nxt), .is_stored(is_stored), .release_data(release_data),
    .local_last_processed(local_last_processed), .out_ready(out_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .err(err),
    .released_cnt(released_cnt), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // ---------------- reference model (queue of tuples) ----------------
  typedef struct packed { logic [SEQ_W-1:0] seq; logic [DATA_W-1:0] data; } ent_t;
  ent_t        q[$];
  bit          md_valid, md_err, md_done, md_last_seen;
  logic [63:0] md_data;
  int unsigned md_rel, md_stall;

  function automatic bit mdl_stored();
    return (q.size() > 0) && (q[0].seq == nxt);
  endfunction

  function automatic bit mdl_stale();
    logic [SEQ_W-1:0] age;
    if (q.size() == 0) return 1'b0;
    age = nxt - q[0].seq;
    return (age != 0) && (age < 32'h8000_0000);
  endfunction

  function automatic bit mdl_sready();
    return (q.size() < DEPTH) && !md_done;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic mdl_check();
    chk("s_ready", s_ready, mdl_sready());
    chk("is_stored", is_stored, mdl_stored());
    chk("out_ready", out_ready, !md_valid || m_ready);
    chk("m_valid", m_valid, md_valid);
    chk("m_data", m_data, md_data);
    chk("err", err, md_err);
    chk("local_last_processed", local_last_processed, md_done);
`ifdef SAR_STATS_EN
    chk("released_cnt", released_cnt, md_rel);
    chk("stall_cnt", stall_cnt, md_stall);
`else
    chk("released_cnt", released_cnt, 0);
    chk("stall_cnt", stall_cnt, 0);
`endif
  endtask

  task automatic mdl_update();
    bit push, st, rel_ok, stale;
    ent_t head;
    if (reset) begin
      q.delete();
      md_valid = 0; md_err = 0; md_done = 0; md_last_seen = 0;
      md_data = '0; md_rel = 0; md_stall = 0;
      return;
    end
    push   = s_valid && mdl_sready();
    st     = mdl_stored();
    stale  = mdl_stale();
    rel_ok = release_data && st && (!md_valid || m_ready);
    if (q.size() > 0) begin
      head = q[0];
      if (!st) md_stall++;
    end
    if (release_data && !rel_ok) md_err = 1;
    if (stale) md_err = 1;
    if (rel_ok || stale) void'(q.pop_front());
    if (push) begin
      q.push_back('{s_seq, s_data});
      if (s_last) md_last_seen = 1;
    end
    if (rel_ok) begin
      md_valid = 1; md_data = head.data; md_rel++;
    end else if (m_ready) md_valid = 0;
    if (md_last_seen && q.size() == 0) md_done = 1;
  endtask

  // Inputs are set just after a falling edge; outputs are checked 1ns later.
  task automatic tick(input bit do_chk);
    #1;
    if (do_chk) mdl_check();
    mdl_update();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    s_valid = 0; s_last = 0; release_data = 0; m_ready = 0;
  endtask

  task automatic do_reset(input bit chk_first);
    reset = 1; idle_inputs();
    tick(chk_first);
    tick(1);
    reset = 0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic sv; logic [31:0] seq; logic [63:0] data; logic last;
    logic [31:0] nx; logic rel; logic mr;
    logic e_sready, e_stored, e_mvalid; logic [63:0] e_mdata; logic e_err;
  } vec_t;
  vec_t tbl[8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit expired");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1, 0, 64'hA0, 0, 0, 0, 1, 1, 0, 0, 64'h0,  0};
    tbl[1] = '{1, 1, 64'hB1, 0, 0, 0, 1, 1, 1, 0, 64'h0,  0};
    tbl[2] = '{1, 2, 64'hC2, 0, 0, 0, 1, 1, 1, 0, 64'h0,  0};
    tbl[3] = '{0, 0, 64'h0,  0, 0, 1, 1, 1, 1, 0, 64'h0,  0};
    tbl[4] = '{0, 0, 64'h0,  0, 1, 1, 1, 1, 1, 1, 64'hA0, 0};
    tbl[5] = '{0, 0, 64'h0,  0, 2, 1, 1, 1, 1, 1, 64'hB1, 0};
    tbl[6] = '{0, 0, 64'h0,  0, 2, 0, 1, 1, 0, 1, 64'hC2, 0};
    tbl[7] = '{0, 0, 64'h0,  0, 2, 0, 1, 1, 0, 0, 64'h0,  0};

    @(negedge clk);
    do_reset(0);

    // In-order release with one-cycle latency and no bubble.
    for (int i = 0; i < 8; i++) begin
      s_valid = tbl[i].sv; s_seq = tbl[i].seq; s_data = tbl[i].data; s_last = tbl[i].last;
      nxt = tbl[i].nx; release_data = tbl[i].rel; m_ready = tbl[i].mr;
      #1;
      chk($sformatf("vec%0d s_ready", i), s_ready, tbl[i].e_sready);
      chk($sformatf("vec%0d is_stored", i), is_stored, tbl[i].e_stored);
      chk($sformatf("vec%0d m_valid", i), m_valid, tbl[i].e_mvalid);
      if (tbl[i].e_mvalid) chk($sformatf("vec%0d m_data", i), m_data, tbl[i].e_mdata);
      chk($sformatf("vec%0d err", i), err, tbl[i].e_err);
      tick(1);
    end

    // Newer head waits; release against it is an error with no pop.
    do_reset(1);
    nxt = 3; s_valid = 1; s_seq = 5; s_data = 64'h55; tick(1);
    s_valid = 0; release_data = 1; m_ready = 1;
    #1 chk("newer is_stored", is_stored, 0);
    tick(1);
    release_data = 0;
    #1 chk("bad release err", err, 1);
    chk("bad release m_valid", m_valid, 0);
    nxt = 5;
    #1 chk("newer now stored", is_stored, 1);
    tick(1);

    // Older head is discarded in one cycle.
    do_reset(1);
    nxt = 4; s_valid = 1; s_seq = 2; s_data = 64'h22; tick(1);
    s_valid = 0; tick(1);
    nxt = 2;
    #1 chk("stale err", err, 1);
    chk("stale emptied", is_stored, 0);
    tick(1);

    // Full buffer back-pressure and recovery.
    do_reset(1);
    nxt = 100; m_ready = 1;
    for (int i = 0; i < DEPTH; i++) begin
      s_valid = 1; s_seq = 100 + i; s_data = 64'(i) + 64'h1000; tick(1);
    end
    s_valid = 0;
    #1 chk("full s_ready", s_ready, 0);
    release_data = 1; tick(1);
    release_data = 0;
    #1 chk("after pop s_ready", s_ready, 1);
    chk("after pop m_data", m_data, 64'h1000);
    s_valid = 1; s_seq = 100 + DEPTH; s_data = 64'hFFFF; tick(1);
    s_valid = 0;
    #1 chk("refill s_ready", s_ready, 0);
    tick(1);

    // Last tuple released -> DONE, then reset clears everything.
    do_reset(1);
    nxt = 7; s_valid = 1; s_seq = 7; s_data = 64'h77; s_last = 1; tick(1);
    s_valid = 0; s_last = 0; release_data = 1; tick(1);
    release_data = 0;
    #1 chk("done llp", local_last_processed, 1);
    chk("done s_ready", s_ready, 0);
    chk("done m_valid", m_valid, 1);
    tick(1);
    do_reset(1);
    #1 chk("post reset llp", local_last_processed, 0);
    chk("post reset m_valid", m_valid, 0);
    chk("post reset s_ready", s_ready, 1);

    // Statistics: 3 releases and 4 stall cycles.
    do_reset(1);
    nxt = 1; m_ready = 1;
    for (int i = 1; i <= 3; i++) begin
      s_valid = 1; s_seq = i; s_data = 64'(i); tick(1);
    end
    s_valid = 0; nxt = 0;
    for (int i = 0; i < 4; i++) tick(1);
    for (int i = 1; i <= 3; i++) begin
      nxt = i; release_data = 1; tick(1);
    end
    release_data = 0;
`ifdef SAR_STATS_EN
    #1 chk("stats released", released_cnt, 3);
    chk("stats stall", stall_cnt, 4);
`else
    #1 chk("stats released", released_cnt, 0);
    chk("stats stall", stall_cnt, 0);
`endif
    tick(1);

    // Randomized traffic including wrap-around tags and mid-run resets.
    do_reset(1);
    for (int c = 0; c < 3000; c++) begin
      logic [SEQ_W-1:0] base;
      base = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC : 32'h0;
      reset        = ($urandom_range(0, 199) == 0);
      s_valid      = ($urandom_range(0, 9) < 6);
      s_seq        = base + $urandom_range(0, 7);
      s_data       = {$urandom, $urandom};
      s_last       = ($urandom_range(0, 99) == 0);
      nxt          = base + $urandom_range(0, 7);
      release_data = ($urandom_range(0, 1) == 1);
      m_ready      = ($urandom_range(0, 9) < 7);
      tick(1);
    end
    reset = 0; idle_inputs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
